// File: rtl/spi_pkg.sv
// Shared constants and FSM encoding for the 24-bit SPI responder.
package spi_pkg;

  localparam int unsigned SPI_FRAME_BITS  = 24;
  localparam int unsigned SPI_SYNC_STAGES = 2;
  localparam int unsigned SPI_CNT_W       = 5;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } spi_state_e;

endpackage

// File: rtl/spi_slave_if.sv
// SPI pins plus the local-side word interface of the responder.
interface spi_slave_if;
  import spi_pkg::*;

  logic                      SCK;
  logic                      CS;
  logic                      MOSI;
  logic                      MISO;
  logic [SPI_FRAME_BITS-1:0] tx_data;
  logic [SPI_FRAME_BITS-1:0] rx_data;
  logic                      rx_valid;
  logic                      frame_error;
  logic                      busy;

  modport slave (
    input  SCK, CS, MOSI, tx_data,
    output MISO, rx_data, rx_valid, frame_error, busy
  );

  modport master (
    output SCK, CS, MOSI, tx_data,
    input  MISO, rx_data, rx_valid, frame_error, busy
  );

endinterface

// File: rtl/spi_sync_edge.sv
// N-flop synchronizer with a history flop and registered rise/fall strobes.
module spi_sync_edge #(
  parameter int unsigned STAGES  = 2,
  parameter logic        RST_VAL = 1'b0
) (
  input  logic clock,
  input  logic reset,
  input  logic d,
  output logic sync,
  output logic rise,
  output logic fall
);

  logic [STAGES-1:0] stage_q;
  logic              hist_q;
  logic              rise_q;
  logic              fall_q;
  logic              last;

  assign last = stage_q[STAGES-1];

  // The history flop doubles as the aligned level output, so sync, rise and
  // fall all describe the same sample.
  always_ff @(posedge clock) begin
    if (reset) begin
      stage_q <= {STAGES{RST_VAL}};
      hist_q  <= RST_VAL;
      rise_q  <= 1'b0;
      fall_q  <= 1'b0;
    end else begin
      stage_q <= {stage_q[STAGES-2:0], d};
      hist_q  <= last;
      rise_q  <= last & ~hist_q;
      fall_q  <= ~last & hist_q;
    end
  end

  assign sync = hist_q;
  assign rise = rise_q;
  assign fall = fall_q;

endmodule

// File: rtl/spi_slave.sv
// SPI responder: oversamples SCK/CS/MOSI, captures one word per CS frame and
// returns a preloaded word on MISO, MSB first.
module spi_slave
  import spi_pkg::*;
#(
  parameter int unsigned DATA_WIDTH  = SPI_FRAME_BITS,
  parameter int unsigned SYNC_STAGES = SPI_SYNC_STAGES
) (
  input  logic        clock,
  input  logic        reset,
  spi_slave_if.slave  bus
);

  localparam logic [SPI_CNT_W-1:0] LAST_BIT = SPI_CNT_W'(DATA_WIDTH - 1);

  logic sck_rise, cs_sync, cs_rise, cs_fall, mosi_sync;
  logic sck_sync_unused, sck_fall_unused, mosi_rise_unused, mosi_fall_unused;

  spi_sync_edge #(.STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_sync_sck (
    .clock (clock),
    .reset (reset),
    .d     (bus.SCK),
    .sync  (sck_sync_unused),
    .rise  (sck_rise),
    .fall  (sck_fall_unused)
  );

  spi_sync_edge #(.STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_sync_cs (
    .clock (clock),
    .reset (reset),
    .d     (bus.CS),
    .sync  (cs_sync),
    .rise  (cs_rise),
    .fall  (cs_fall)
  );

  spi_sync_edge #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_mosi (
    .clock (clock),
    .reset (reset),
    .d     (bus.MOSI),
    .sync  (mosi_sync),
    .rise  (mosi_rise_unused),
    .fall  (mosi_fall_unused)
  );

  spi_state_e              state_q;
  logic [DATA_WIDTH-2:0]   tx_shift_q, tx_shift_d;
  logic [DATA_WIDTH-2:0]   rx_shift_q, rx_shift_d;
  logic [DATA_WIDTH-1:0]   rx_word_d;
  logic [DATA_WIDTH-1:0]   rx_data_q;
  logic [SPI_CNT_W-1:0]    bit_cnt_q, bit_cnt_d;
  logic                    miso_q, rx_valid_q, frame_error_q, busy_q;

  // MISO is the registered head of the reply word, so each shifter only keeps
  // the DATA_WIDTH-1 bits behind it; the received word completes with MOSI.
  always_comb begin
    tx_shift_d = {tx_shift_q[DATA_WIDTH-3:0], 1'b0};
    rx_shift_d = {rx_shift_q[DATA_WIDTH-3:0], mosi_sync};
    rx_word_d  = {rx_shift_q, mosi_sync};
    bit_cnt_d  = bit_cnt_q + 1'b1;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q       <= ST_IDLE;
      tx_shift_q    <= '0;
      rx_shift_q    <= '0;
      rx_data_q     <= '0;
      bit_cnt_q     <= '0;
      miso_q        <= 1'b0;
      rx_valid_q    <= 1'b0;
      frame_error_q <= 1'b0;
      busy_q        <= 1'b0;
    end else begin
      rx_valid_q    <= 1'b0;
      frame_error_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          miso_q <= 1'b0;
          busy_q <= 1'b0;
          if (cs_rise) begin
            tx_shift_q <= bus.tx_data[DATA_WIDTH-2:0];
            miso_q     <= bus.tx_data[DATA_WIDTH-1];
            bit_cnt_q  <= '0;
            busy_q     <= 1'b1;
            state_q    <= ST_SHIFT;
          end
        end
        ST_SHIFT: begin
          // A CS fall in the same cycle as an SCK rise discards that edge.
          if (cs_fall) begin
            frame_error_q <= 1'b1;
            busy_q        <= 1'b0;
            miso_q        <= 1'b0;
            state_q       <= ST_IDLE;
          end else if (sck_rise && cs_sync) begin
            rx_shift_q <= rx_shift_d;
            tx_shift_q <= tx_shift_d;
            bit_cnt_q  <= bit_cnt_d;
            miso_q     <= tx_shift_q[DATA_WIDTH-2];
            if (bit_cnt_q == LAST_BIT) begin
              rx_data_q  <= rx_word_d;
              rx_valid_q <= 1'b1;
              miso_q     <= 1'b0;
              state_q    <= ST_DONE;
            end
          end
        end
        ST_DONE: begin
          miso_q <= 1'b0;
          if (cs_fall) begin
            busy_q  <= 1'b0;
            state_q <= ST_IDLE;
          end
        end
        default: begin
          miso_q  <= 1'b0;
          busy_q  <= 1'b0;
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  assign bus.MISO        = miso_q;
  assign bus.rx_data     = rx_data_q;
  assign bus.rx_valid    = rx_valid_q;
  assign bus.frame_error = frame_error_q;
  assign bus.busy        = busy_q;

endmodule
